// File: rtl/wb_stage.sv
// Writeback stage: formats the integer result and drives both RF write ports.
// Double-precision FP results are written as two 32-bit halves over two cycles.
module wb_stage #(
  parameter int width = 179
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:width-1] in,
  input  logic             fDouble,
  output logic             regWrite,
  output logic [0:4]       regDest,
  output logic [0:31]      regData,
  output logic             fpWrite,
  output logic [0:4]       fpDest,
  output logic [0:31]      fpData,
  output logic             stall,
  output logic             halted
);

  typedef enum logic {IDLE, SECOND} stateT;

  stateT state;

  logic [0:31] nextPC;
  logic [0:4]  destReg;
  logic [0:31] aluResult;
  logic [0:31] dataOut;
  logic        pcToReg;
  logic        wantRegWrite;
  logic        memToReg;
  logic        loadSign;
  logic [0:1]  dSize;
  logic        trap;
  logic [0:4]  fDestReg;
  logic [0:31] fbusHi;
  logic [0:31] fbusLo;
  logic        fpRegWrite;
  logic        mulSel;

  assign nextPC       = in[0:31];
  assign destReg      = in[32:36];
  assign aluResult    = in[37:68];
  assign dataOut      = in[69:100];
  assign pcToReg      = in[101];
  assign wantRegWrite = in[102];
  assign memToReg     = in[103];
  assign loadSign     = in[104];
  assign dSize        = in[105:106];
  assign trap         = in[107];
  assign fDestReg     = in[108:112];
  assign fbusHi       = in[113:144];
  assign fbusLo       = in[145:176];
  assign fpRegWrite   = in[177];
  assign mulSel       = in[178];

  logic [0:3]  capDest;
  logic [0:31] capLo;
  logic [0:31] loadVal;
  logic        live;
  logic        idle;

  assign live = ~reset & ~halted & ~trap;
  assign idle = (state == IDLE);

  always_comb begin
    unique case (dSize)
      2'b00:   loadVal = {{24{loadSign & dataOut[24]}},
                          dataOut[24:31]};
      2'b01:   loadVal = {{16{loadSign & dataOut[16]}},
                          dataOut[16:31]};
      default: loadVal = dataOut;
    endcase
  end

  // PCtoReg and MemToReg may both be set; the chain encodes precedence
  always_comb begin
    if (pcToReg)       regData = nextPC;
    else if (mulSel)   regData = fbusLo;
    else if (memToReg) regData = loadVal;
    else               regData = aluResult;
  end

  assign regDest  = destReg;
  assign regWrite = idle & live & wantRegWrite
                  & (destReg != 5'd0);

  always_comb begin
    fpWrite = 1'b0;
    fpDest  = fDestReg;
    fpData  = fbusLo;
    stall   = 1'b0;
    if (!idle && !reset) begin
      fpWrite = ~halted & ~trap;
      fpDest  = {capDest, 1'b1};
      fpData  = capLo;
    end else if (fpRegWrite) begin
      fpWrite = live;
      if (fDouble) begin
        fpDest = {fDestReg[0:3], 1'b0};
        fpData = fbusHi;
        stall  = live;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      halted  <= 1'b0;
      capDest <= '0;
      capLo   <= '0;
    end else begin
      if (idle && trap) halted <= 1'b1;
      unique case (state)
        IDLE: begin
          if (stall) begin
            state   <= SECOND;
            capDest <= fDestReg[0:3];
            capLo   <= fbusLo;
          end
        end
        SECOND: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
// Expected values are hand-computed constants.
module tb_wb_stage;

  logic         clk;
  logic         reset;
  logic [0:178] bus;
  logic         fDouble;
  logic         regWrite;
  logic [0:4]   regDest;
  logic [0:31]  regData;
  logic         fpWrite;
  logic [0:4]   fpDest;
  logic [0:31]  fpData;
  logic         stall;
  logic         halted;

  int checks = 0;
  int errors = 0;

  wb_stage #(.width(179)) dut (
    .clk(clk),
    .reset(reset),
    .in(bus),
    .fDouble(fDouble),
    .regWrite(regWrite),
    .regDest(regDest),
    .regData(regData),
    .fpWrite(fpWrite),
    .fpDest(fpDest),
    .fpData(fpData),
    .stall(stall),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag,
                          input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic aluBus;
    bus = '0;
    bus[102] = 1'b1;
    bus[32:36] = 5'd5;
    bus[37:68] = 32'h12345678;
  endtask

  task automatic fpBus(input logic [4:0] d,
                       input logic [63:0] v);
    bus = '0;
    bus[177] = 1'b1;
    bus[108:112] = d;
    bus[113:176] = v;
  endtask

  task automatic loadBus(input logic [1:0] sz,
                         input logic sg,
                         input logic [31:0] d);
    bus = '0;
    bus[102] = 1'b1;
    bus[32:36] = 5'd3;
    bus[103] = 1'b1;
    bus[104] = sg;
    bus[105:106] = sz;
    bus[69:100] = d;
  endtask

  initial begin
    reset = 1'b1;
    bus = '0;
    fDouble = 1'b0;
    tick;
    aluBus;
    settle;
    checkVal("rst_regWrite", regWrite, 0);
    checkVal("rst_fpWrite", fpWrite, 0);
    checkVal("rst_stall", stall, 0);
    checkVal("rst_halted", halted, 0);

    tick;
    reset = 1'b0;
    aluBus;
    settle;
    checkVal("alu_we", regWrite, 1);
    checkVal("alu_dest", regDest, 5);
    checkVal("alu_data", regData, 32'h12345678);
    checkVal("alu_fpwe", fpWrite, 0);
    checkVal("alu_stall", stall, 0);

    tick;
    loadBus(2'b00, 1'b1, 32'h000000F0);
    settle;
    checkVal("lb_data", regData, 32'hFFFFFFF0);
    checkVal("lb_we", regWrite, 1);
    loadBus(2'b00, 1'b0, 32'h000000F0);
    settle;
    checkVal("lbu_data", regData, 32'h000000F0);
    loadBus(2'b01, 1'b1, 32'h00008001);
    settle;
    checkVal("lh_data", regData, 32'hFFFF8001);
    loadBus(2'b01, 1'b0, 32'h00008001);
    settle;
    checkVal("lhu_data", regData, 32'h00008001);
    loadBus(2'b10, 1'b1, 32'h8765_4321);
    settle;
    checkVal("lw_data", regData, 32'h87654321);

    bus = '0;
    bus[102] = 1'b1;
    bus[32:36] = 5'd9;
    bus[101] = 1'b1;
    bus[103] = 1'b1;
    bus[0:31] = 32'h100;
    bus[69:100] = 32'hCAFE0000;
    settle;
    checkVal("pc_data", regData, 32'h100);
    checkVal("pc_we", regWrite, 1);
    bus[32:36] = 5'd0;
    settle;
    checkVal("r0_we", regWrite, 0);

    bus = '0;
    bus[102] = 1'b1;
    bus[32:36] = 5'd2;
    bus[178] = 1'b1;
    bus[103] = 1'b1;
    bus[113:176] = 64'h0123456_7DEADBEEF;
    settle;
    checkVal("mul_data", regData, 32'hDEADBEEF);

    tick;
    fpBus(5'd7, 64'h11111111_22222222);
    settle;
    checkVal("sgl_we", fpWrite, 1);
    checkVal("sgl_dest", fpDest, 7);
    checkVal("sgl_data", fpData, 32'h22222222);
    checkVal("sgl_stall", stall, 0);

    fpBus(5'd4, 64'hAAAAAAAA_55555555);
    fDouble = 1'b1;
    bus[102] = 1'b1;
    bus[32:36] = 5'd6;
    settle;
    checkVal("dbl0_we", fpWrite, 1);
    checkVal("dbl0_dest", fpDest, 4);
    checkVal("dbl0_data", fpData, 32'hAAAAAAAA);
    checkVal("dbl0_stall", stall, 1);
    checkVal("dbl0_rwe", regWrite, 1);
    tick;
    checkVal("dbl1_we", fpWrite, 1);
    checkVal("dbl1_dest", fpDest, 5);
    checkVal("dbl1_data", fpData, 32'h55555555);
    checkVal("dbl1_stall", stall, 0);
    checkVal("dbl1_rwe", regWrite, 0);
    tick;
    fDouble = 1'b0;
    aluBus;
    settle;
    checkVal("dbl2_rwe", regWrite, 1);
    checkVal("dbl2_fpwe", fpWrite, 0);
    checkVal("dbl2_stall", stall, 0);

    tick;
    fpBus(5'd5, 64'h33333333_44444444);
    fDouble = 1'b1;
    settle;
    checkVal("odd0_dest", fpDest, 4);
    checkVal("odd0_data", fpData, 32'h33333333);
    tick;
    checkVal("odd1_dest", fpDest, 5);
    checkVal("odd1_data", fpData, 32'h44444444);
    checkVal("odd1_we", fpWrite, 1);

    tick;
    fDouble = 1'b0;
    bus = '0;
    settle;
    checkVal("bub_rwe", regWrite, 0);
    checkVal("bub_fpwe", fpWrite, 0);
    checkVal("bub_stall", stall, 0);

    tick;
    aluBus;
    bus[107] = 1'b1;
    settle;
    checkVal("trap_rwe", regWrite, 0);
    checkVal("trap_halt0", halted, 0);
    tick;
    aluBus;
    settle;
    checkVal("halt_set", halted, 1);
    checkVal("halt_rwe", regWrite, 0);
    tick;
    fpBus(5'd7, 64'h11111111_22222222);
    settle;
    checkVal("halt_fpwe", fpWrite, 0);
    tick;
    fpBus(5'd4, 64'hAAAAAAAA_55555555);
    fDouble = 1'b1;
    settle;
    checkVal("halt_dbl_we", fpWrite, 0);
    checkVal("halt_dbl_stall", stall, 0);
    tick;
    checkVal("halt_dbl1_we", fpWrite, 0);
    checkVal("halt_hold", halted, 1);

    reset = 1'b1;
    settle;
    checkVal("rstp_fpwe", fpWrite, 0);
    tick;
    reset = 1'b0;
    fDouble = 1'b0;
    aluBus;
    settle;
    checkVal("rstp_halted", halted, 0);
    checkVal("rstp_rwe", regWrite, 1);

    tick;
    fpBus(5'd2, 64'hAAAAAAAA_55555555);
    fDouble = 1'b1;
    settle;
    checkVal("mid0_stall", stall, 1);
    tick;
    reset = 1'b1;
    settle;
    checkVal("mid1_fpwe", fpWrite, 0);
    checkVal("mid1_stall", stall, 0);
    tick;
    reset = 1'b0;
    fDouble = 1'b0;
    fpBus(5'd7, 64'h11111111_22222222);
    settle;
    checkVal("mid2_we", fpWrite, 1);
    checkVal("mid2_dest", fpDest, 7);
    checkVal("mid2_data", fpData, 32'h22222222);
    checkVal("mid2_stall", stall, 0);

    tick;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
